// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v position counters gated by a pixel
// enable, with registered position, visibility, sync and line/frame markers.
module vga_sync_gen #(
  parameter int unsigned H_VIS_AREA_PXL    = 200,
  parameter int unsigned H_FRONT_PORCH_PXL = 10,
  parameter int unsigned H_SYNC_PULSE_PXL  = 32,
  parameter int unsigned H_BACK_PORCH_PXL  = 22,
  parameter int unsigned H_NUM_BITS        = 9,
  parameter int unsigned V_VIS_AREA_PXL    = 600,
  parameter int unsigned V_FRONT_PORCH_PXL = 1,
  parameter int unsigned V_SYNC_PULSE_PXL  = 4,
  parameter int unsigned V_BACK_PORCH_PXL  = 23,
  parameter int unsigned V_NUM_BITS        = 10,
  parameter logic        H_SYNC_POL        = 1'b0,
  parameter logic        V_SYNC_POL        = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  output logic [H_NUM_BITS-1:0] x,
  output logic [V_NUM_BITS-1:0] y,
  output logic                  visible,
  output logic                  pixel_valid,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  h_sync,
  output logic                  v_sync
);

  localparam int unsigned H_TOTAL = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL
                                  + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
  localparam int unsigned V_TOTAL = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL
                                  + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;

  localparam int unsigned H_SYNC_START = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE_PXL;
  localparam int unsigned V_SYNC_START = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE_PXL;

  localparam logic [H_NUM_BITS-1:0] H_LAST = H_NUM_BITS'(H_TOTAL - 1);
  localparam logic [V_NUM_BITS-1:0] V_LAST = V_NUM_BITS'(V_TOTAL - 1);

  if (H_TOTAL == 0 || H_TOTAL > 2 ** H_NUM_BITS) begin : g_bad_h
    $error("vga_sync_gen: H_TOTAL does not fit in H_NUM_BITS");
  end
  if (V_TOTAL == 0 || V_TOTAL > 2 ** V_NUM_BITS) begin : g_bad_v
    $error("vga_sync_gen: V_TOTAL does not fit in V_NUM_BITS");
  end

  logic [H_NUM_BITS-1:0] r_h_cnt;
  logic [V_NUM_BITS-1:0] r_v_cnt;

  logic [31:0] w_h_ext;
  logic [31:0] w_v_ext;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_h_vis;
  logic        w_v_vis;
  logic        w_h_sync_act;
  logic        w_v_sync_act;
  logic        w_h_zero;
  logic        w_v_zero;

  // Region compares are done on 32-bit copies so a sync window ending
  // exactly at 2^N_BITS is not truncated to zero.
  always_comb begin
    w_h_ext      = 32'(r_h_cnt);
    w_v_ext      = 32'(r_v_cnt);
    w_h_last     = (r_h_cnt == H_LAST);
    w_v_last     = (r_v_cnt == V_LAST);
    w_h_vis      = (w_h_ext < H_VIS_AREA_PXL);
    w_v_vis      = (w_v_ext < V_VIS_AREA_PXL);
    w_h_sync_act = (w_h_ext >= H_SYNC_START) && (w_h_ext < H_SYNC_END);
    w_v_sync_act = (w_v_ext >= V_SYNC_START) && (w_v_ext < V_SYNC_END);
    w_h_zero     = (r_h_cnt == '0);
    w_v_zero     = (r_v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Outputs describe the pre-edge counter pair, one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      visible     <= 1'b0;
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
    end else begin
      x           <= r_h_cnt;
      y           <= r_v_cnt;
      visible     <= w_h_vis && w_v_vis;
      pixel_valid <= pix_en;
      line_start  <= pix_en && w_h_zero;
      frame_start <= pix_en && w_h_zero && w_v_zero;
      h_sync      <= w_h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync      <= w_v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing, inverted-polarity tall-line copy,
// and a narrow-line copy that reaches the default vertical sync quickly.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_bc, en_bc;
  logic [8:0] xa;  logic [9:0] ya;
  logic       vis_a, pv_a, ls_a, fs_a, hs_a, vs_a;
  logic [8:0] xb;  logic [3:0] yb;
  logic       vis_b, pv_b, ls_b, fs_b, hs_b, vs_b;
  logic [3:0] xc;  logic [9:0] yc;
  logic       vis_c, pv_c, ls_c, fs_c, hs_c, vs_c;

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_en(en_a), .x(xa), .y(ya), .visible(vis_a),
    .pixel_valid(pv_a), .line_start(ls_a), .frame_start(fs_a),
    .h_sync(hs_a), .v_sync(vs_a)
  );

  // Default horizontal timing, 12-line frame, both syncs active-high.
  vga_sync_gen #(
    .V_VIS_AREA_PXL(6), .V_FRONT_PORCH_PXL(1), .V_SYNC_PULSE_PXL(2),
    .V_BACK_PORCH_PXL(3), .V_NUM_BITS(4), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_bc), .pix_en(en_bc), .x(xb), .y(yb), .visible(vis_b),
    .pixel_valid(pv_b), .line_start(ls_b), .frame_start(fs_b),
    .h_sync(hs_b), .v_sync(vs_b)
  );

  // 16-pixel lines filling a 4-bit counter exactly, default vertical timing.
  vga_sync_gen #(
    .H_VIS_AREA_PXL(8), .H_FRONT_PORCH_PXL(2), .H_SYNC_PULSE_PXL(3),
    .H_BACK_PORCH_PXL(3), .H_NUM_BITS(4)
  ) dut_c (
    .clk(clk), .reset(rst_bc), .pix_en(en_bc), .x(xc), .y(yc), .visible(vis_c),
    .pixel_valid(pv_c), .line_start(ls_c), .frame_start(fs_c),
    .h_sync(hs_c), .v_sync(vs_c)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs for counter pair at pixel index p (counted from (0,0)).
  task automatic chk_pix(input string pf, input int unsigned p, input logic en,
                         input int unsigned hv, hss, hse, ht,
                         input int unsigned vv, vss, vse, vt,
                         input logic hpol, vpol,
                         input int unsigned ox, oy,
                         input logic ovis, opv, ols, ofs, ohs, ovs);
    int unsigned ex, ey;
    ex = p % ht;
    ey = (p / ht) % vt;
    chk({pf, ".x"}, ox, ex);
    chk({pf, ".y"}, oy, ey);
    chk({pf, ".visible"}, 32'(ovis), 32'(ex < hv && ey < vv));
    chk({pf, ".pixel_valid"}, 32'(opv), 32'(en));
    chk({pf, ".line_start"}, 32'(ols), 32'(en && ex == 0));
    chk({pf, ".frame_start"}, 32'(ofs), 32'(en && ex == 0 && ey == 0));
    chk({pf, ".h_sync"}, 32'(ohs), 32'((ex >= hss && ex < hse) ? hpol : !hpol));
    chk({pf, ".v_sync"}, 32'(ovs), 32'((ey >= vss && ey < vse) ? vpol : !vpol));
  endtask

  task automatic chk_a(input int unsigned p, input logic en);
    chk_pix("a", p, en, 200, 210, 242, 264, 600, 601, 605, 628, 1'b0, 1'b0,
            xa, ya, vis_a, pv_a, ls_a, fs_a, hs_a, vs_a);
  endtask

  task automatic chk_b(input int unsigned p, input logic en);
    chk_pix("b", p, en, 200, 210, 242, 264, 6, 7, 9, 12, 1'b1, 1'b1,
            xb, yb, vis_b, pv_b, ls_b, fs_b, hs_b, vs_b);
  endtask

  task automatic chk_c(input int unsigned p, input logic en);
    chk_pix("c", p, en, 8, 10, 13, 16, 600, 601, 605, 628, 1'b0, 1'b0,
            xc, yc, vis_c, pv_c, ls_c, fs_c, hs_c, vs_c);
  endtask

  task automatic chk_rst(input string pf, input logic hpol, vpol,
                         input int unsigned ox, oy,
                         input logic ovis, opv, ols, ofs, ohs, ovs);
    chk({pf, ".rst_x"}, ox, 0);
    chk({pf, ".rst_y"}, oy, 0);
    chk({pf, ".rst_visible"}, 32'(ovis), 0);
    chk({pf, ".rst_pixel_valid"}, 32'(opv), 0);
    chk({pf, ".rst_line_start"}, 32'(ols), 0);
    chk({pf, ".rst_frame_start"}, 32'(ofs), 0);
    chk({pf, ".rst_h_sync"}, 32'(ohs), 32'(!hpol));
    chk({pf, ".rst_v_sync"}, 32'(ovs), 32'(!vpol));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pa, q;
    int last_ls, n_ls, hs_low, last_fb, last_fc, vlow_c, hs_high_b;
    logic prev_ls;

    rst_a = 1'b1; en_a = 1'b1; rst_bc = 1'b1; en_bc = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst("a", 1'b0, 1'b0, xa, ya, vis_a, pv_a, ls_a, fs_a, hs_a, vs_a);
    chk_rst("b", 1'b1, 1'b1, xb, yb, vis_b, pv_b, ls_b, fs_b, hs_b, vs_b);
    chk_rst("c", 1'b0, 1'b0, xc, yc, vis_c, pv_c, ls_c, fs_c, hs_c, vs_c);

    // Default instance: continuous enable across two lines.
    rst_a = 1'b0;
    pa = 0; last_ls = -1; n_ls = 0; hs_low = 0;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      chk_a(pa, 1'b1);
      if (pa < 264 && hs_a == 1'b0) hs_low++;
      if (ls_a) begin
        if (last_ls >= 0) chk("a.ls_period", 32'(i - last_ls), 264);
        last_ls = i;
        n_ls++;
      end
      pa++;
    end
    chk("a.hs_low_cycles", 32'(hs_low), 32);
    chk("a.ls_count", 32'(n_ls), 2);

    // Toggled enable across a line boundary.
    prev_ls = 1'b0;
    for (int i = 0; i < 40; i++) begin
      en_a = (i % 2 == 0);
      @(negedge clk);
      chk_a(pa, en_a);
      chk("a.ls_two_wide", 32'(ls_a && prev_ls), 0);
      prev_ls = ls_a;
      if (en_a) pa++;
    end

    // Mid-line reset at x=150, then release with one idle cycle.
    en_a = 1'b1;
    for (int i = 0; i < 264 && (pa % 264) != 150; i++) begin
      @(negedge clk);
      chk_a(pa, 1'b1);
      pa++;
    end
    @(negedge clk);
    chk_a(pa, 1'b1);
    chk("a.x_before_rst", 32'(xa), 150);
    rst_a = 1'b1;
    @(negedge clk);
    chk_rst("a", 1'b0, 1'b0, xa, ya, vis_a, pv_a, ls_a, fs_a, hs_a, vs_a);
    rst_a = 1'b0; en_a = 1'b0;
    @(negedge clk);
    chk_a(0, 1'b0);
    en_a = 1'b1; pa = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_a(pa, 1'b1);
      pa++;
    end

    // Tall-line inverted copy and narrow-line copy, past one full frame of c.
    rst_bc = 1'b0;
    q = 0; last_fb = -1; last_fc = -1; vlow_c = 0; hs_high_b = 0;
    for (int i = 0; i < 10048 + 40; i++) begin
      @(negedge clk);
      chk_b(q, 1'b1);
      chk_c(q, 1'b1);
      if (fs_b) begin
        if (last_fb >= 0) chk("b.fs_period", q - 32'(last_fb), 3168);
        last_fb = int'(q);
      end
      if (fs_c) begin
        if (last_fc >= 0) chk("c.fs_period", q - 32'(last_fc), 10048);
        last_fc = int'(q);
      end
      if (q < 10048 && vs_c == 1'b0) vlow_c++;
      if (q < 264 && hs_b == 1'b1) hs_high_b++;
      q++;
    end
    chk("c.vs_low_cycles", 32'(vlow_c), 64);
    chk("b.hs_high_cycles", 32'(hs_high_b), 32);
    chk("c.fs_seen", 32'(last_fc), 10048);

    // Mid-frame reset of c at y=300, x=10.
    while (q < 10048 + 300 * 16 + 10) begin
      @(negedge clk);
      chk_b(q, 1'b1);
      chk_c(q, 1'b1);
      q++;
    end
    @(negedge clk);
    chk_c(q, 1'b1);
    chk("c.y_before_rst", 32'(yc), 300);
    rst_bc = 1'b1;
    @(negedge clk);
    chk_rst("b", 1'b1, 1'b1, xb, yb, vis_b, pv_b, ls_b, fs_b, hs_b, vs_b);
    chk_rst("c", 1'b0, 1'b0, xc, yc, vis_c, pv_c, ls_c, fs_c, hs_c, vs_c);
    rst_bc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b(i, 1'b1);
      chk_c(i, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- H_VIS_AREA_PXL, 200, visible pixels per line
- H_FRONT_PORCH_PXL, 10, horizontal front porch pixels
- H_SYNC_PULSE_PXL, 32, horizontal sync pulse pixels
- H_BACK_PORCH_PXL, 22, horizontal back porch pixels
- H_NUM_BITS, 9, width of x / h counter
- V_VIS_AREA_PXL, 600, visible lines per frame
- V_FRONT_PORCH_PXL, 1, vertical front porch lines
- V_SYNC_PULSE_PXL, 4, vertical sync pulse lines
- V_BACK_PORCH_PXL, 23, vertical back porch lines
- V_NUM_BITS, 10, width of y / v counter
- H_SYNC_POL, 0, h_sync active level (0 = active-low)
- V_SYNC_POL, 0, v_sync active level (0 = active-low)

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, system clock; one clock domain only
- reset, in, 1, synchronous, active-high
- pix_en, in, 1, pixel-clock enable; one pixel per cycle with pix_en=1
- x, out, H_NUM_BITS, horizontal position of the current output pixel
- y, out, V_NUM_BITS, vertical position of the current output pixel
- visible, out, 1, the current output pixel is in the visible area
- pixel_valid, out, 1, the outputs describe a new pixel this cycle
- line_start, out, 1, one-cycle pulse on pixel x=0
- frame_start, out, 1, one-cycle pulse on pixel (0,0)
- h_sync, out, 1, horizontal sync
- v_sync, out, 1, vertical sync

Function
REQ-003 H_TOTAL SHALL be the sum of the four H_* parameters (default 264); V_TOTAL SHALL be the sum of the four V_* parameters (default 628).
REQ-004 Internal counters h_cnt and v_cnt SHALL advance only on clk edges where pix_en=1; with pix_en=0 they SHALL hold.
REQ-005 With pix_en=1: if h_cnt<H_TOTAL-1 then h_cnt SHALL increment; otherwise h_cnt SHALL wrap to 0 and v_cnt SHALL advance.
REQ-006 v_cnt SHALL increment on each h_cnt wrap and SHALL wrap from V_TOTAL-1 to 0 when h_cnt also wraps; the counters SHALL never take values >= H_TOTAL or >= V_TOTAL.
REQ-007 Every output SHALL be registered and updated on every clk edge from the pre-edge counter values, giving 1-cycle latency; all outputs in a given cycle SHALL describe the same (h_cnt, v_cnt) pair.
REQ-008 x <= h_cnt and y <= v_cnt.
REQ-009 visible <= (h_cnt < H_VIS_AREA_PXL) && (v_cnt < V_VIS_AREA_PXL).
REQ-010 h_sync SHALL be H_SYNC_POL when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, and ~H_SYNC_POL otherwise.
REQ-011 v_sync SHALL follow the same rule on v_cnt with the V_* parameters and V_SYNC_POL, and SHALL be independent of h_cnt.
REQ-012 pixel_valid <= pix_en.
REQ-013 line_start <= pix_en && h_cnt==0.
REQ-014 frame_start <= pix_en && h_cnt==0 && v_cnt==0.
REQ-015 line_start and frame_start SHALL therefore pulse exactly once per line and once per frame respectively, regardless of gaps in pix_en.
REQ-016 Comparisons SHALL be unsigned, at H_NUM_BITS / V_NUM_BITS width; parameters SHALL satisfy H_TOTAL <= 2^H_NUM_BITS and V_TOTAL <= 2^V_NUM_BITS.

Reset
REQ-017 While reset=1 at a clk edge, the following SHALL hold at that edge, overriding pix_en:
- h_cnt, v_cnt, x, y SHALL be 0
- visible, pixel_valid, line_start and frame_start SHALL be 0
- h_sync SHALL be ~H_SYNC_POL and v_sync SHALL be ~V_SYNC_POL
REQ-018 Reset asserted mid-line or mid-frame SHALL abort the current position. The first pix_en=1 cycle after release SHALL yield, one cycle later, x=0, y=0, visible=1, line_start=1 and frame_start=1.

Verification
REQ-019 Reset, then pix_en=1 held -> first output cycle x=0, y=0, visible=1, frame_start=1, line_start=1, h_sync=1, v_sync=1 (defaults).
REQ-020 pix_en=1 continuous for one line -> visible high for x=0..199; h_sync=0 exactly for x=210..241 (32 cycles); line_start period 264 cycles.
REQ-021 pix_en=1 continuous -> frame_start period 165792 cycles; v_sync=0 exactly for y=601..604; y wraps 627->0 coincident with x 263->0.
REQ-022 pix_en toggling 1,0,1,0 -> x advances once per pix_en pulse; pixel_valid mirrors pix_en delayed by one cycle; line_start is never 2 cycles wide.
REQ-023 reset pulsed at x=150, y=300 -> outputs go to reset values next cycle; with pix_en=1, the output sequence restarts at (0,0) with frame_start=1.
REQ-024 H_SYNC_POL=1, V_SYNC_POL=1 -> sync waveforms inverted relative to REQ-020 and REQ-021, with identical timing.
